// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants, FSM state encoding and op-class helpers shared by the ALU
package alu_pkg;
  typedef logic [4:0] op_t;
  localparam op_t ALU_LUI    = 5'd0;
  localparam op_t ALU_ADD    = 5'd1;
  localparam op_t ALU_SUB    = 5'd2;
  localparam op_t ALU_ADD4   = 5'd3;
  localparam op_t ALU_BEQ    = 5'd4;
  localparam op_t ALU_BNE    = 5'd5;
  localparam op_t ALU_BLT    = 5'd6;
  localparam op_t ALU_BGE    = 5'd7;
  localparam op_t ALU_BLTU   = 5'd8;
  localparam op_t ALU_BGEU   = 5'd9;
  localparam op_t ALU_SLL    = 5'd10;
  localparam op_t ALU_SRL    = 5'd11;
  localparam op_t ALU_SRA    = 5'd12;
  localparam op_t ALU_AND    = 5'd13;
  localparam op_t ALU_OR     = 5'd14;
  localparam op_t ALU_XOR    = 5'd15;
  localparam op_t ALU_SLT    = 5'd16;
  localparam op_t ALU_SLTU   = 5'd17;
  localparam op_t ALU_MUL    = 5'd18;
  localparam op_t ALU_MULH   = 5'd19;
  localparam op_t ALU_MULHSU = 5'd20;
  localparam op_t ALU_MULHU  = 5'd21;
  localparam op_t ALU_DIV    = 5'd22;
  localparam op_t ALU_DIVU   = 5'd23;
  localparam op_t ALU_REM    = 5'd24;
  localparam op_t ALU_REMU   = 5'd25;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  function automatic logic is_mul(op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction
  function automatic logic is_div(op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiplier / restoring divider, XLEN iterations per op
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  op_t             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] hi, lo, m, hi_n, lo_n, ma, mb, q, r;
  logic [XLEN:0] sum, rsh, diff;
  logic [2*XLEN-1:0] p;
  logic [CW-1:0] cnt;
  logic dv, hsel, neg, negr, an, bn;
  // Work on magnitudes; sign is restored on the final iteration's values
  always_comb begin
    an = a[XLEN-1] && (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    bn = b[XLEN-1] && (op inside {ALU_MULH, ALU_DIV, ALU_REM});
    ma = an ? -a : a;
    mb = bn ? -b : b;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rsh = {hi, lo[XLEN-1]};
    diff = rsh - {1'b0, m};
    hi_n = dv ? (diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n = dv ? {lo[XLEN-2:0], !diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
    p = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
    q = neg ? -lo_n : lo_n;
    r = negr ? -hi_n : hi_n;
    res = dv ? (hsel ? r : q) : (hsel ? p[2*XLEN-1:XLEN] : p[XLEN-1:0]);
  end
  assign done = busy && cnt == CW'(XLEN - 1);
  // A zero divisor leaves the quotient unnegated so it reads all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      dv <= 1'b0;
      hsel <= 1'b0;
      neg <= 1'b0;
      negr <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      hi <= '0;
      dv <= is_div(op);
      lo <= is_div(op) ? ma : mb;
      m <= is_div(op) ? mb : ma;
      hsel <= op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
      neg <= (an ^ bn) && (!is_div(op) || b != '0);
      negr <= an;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + CW'(1);
      busy <= !done;
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle ALU ops plus iterative M-extension ops behind a valid/ready handshake
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            taken
);
  localparam int SW = $clog2(XLEN);
  state_t state, nxt;
  op_t o;
  logic acc, md_start, md_busy, md_done, md_act, alu_taken;
  logic [XLEN-1:0] md_res, alu_res;
  logic [SW-1:0] sh;
  assign o = op_t'(op);
  assign sh = src2[SW-1:0];
  assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
  assign acc = in_valid && in_ready;
  assign md_start = acc && (is_mul(o) || is_div(o));
  assign md_act = state == MUL || state == DIV;
  assign out_valid = state == DONE;
  alu_muldiv_seq #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(md_start), .op(o),
    .a(src1), .b(src2), .busy(md_busy), .done(md_done), .res(md_res)
  );
  always_comb begin
    alu_res = '0;
    alu_taken = 1'b0;
    case (o)
      ALU_LUI:  alu_res = src2;
      ALU_ADD:  alu_res = src1 + src2;
      ALU_SUB:  alu_res = src1 - src2;
      ALU_ADD4: begin
        alu_res = src1 + XLEN'(4);
        alu_taken = 1'b1;
      end
      ALU_BEQ:  alu_taken = src1 == src2;
      ALU_BNE:  alu_taken = src1 != src2;
      ALU_BLT:  alu_taken = $signed(src1) < $signed(src2);
      ALU_BGE:  alu_taken = $signed(src1) >= $signed(src2);
      ALU_BLTU: alu_taken = src1 < src2;
      ALU_BGEU: alu_taken = src1 >= src2;
      ALU_SLL:  alu_res = src1 << sh;
      ALU_SRL:  alu_res = src1 >> sh;
      ALU_SRA:  alu_res = $signed(src1) >>> sh;
      ALU_AND:  alu_res = src1 & src2;
      ALU_OR:   alu_res = src1 | src2;
      ALU_XOR:  alu_res = src1 ^ src2;
      ALU_SLT:  alu_res = XLEN'($signed(src1) < $signed(src2));
      ALU_SLTU: alu_res = XLEN'(src1 < src2);
      default:  ;
    endcase
  end
  // A lost busy while iterating can only follow an abort, so fall back to IDLE
  always_comb begin
    nxt = state;
    if (state == DONE && out_ready) nxt = IDLE;
    if (md_act && (md_done || !md_busy)) nxt = md_done ? DONE : IDLE;
    if (acc) nxt = is_mul(o) ? MUL : is_div(o) ? DIV : DONE;
    if (flush) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      taken <= 1'b0;
    end else begin
      state <= nxt;
      if (flush) begin
        result <= '0;
        taken <= 1'b0;
      end else if (acc && !md_start) begin
        result <= alu_res;
        taken <= alu_taken;
      end else if (md_act && md_done) begin
        result <= md_res;
        taken <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with a queue scoreboard checked by an independent monitor
module tb_alu_multicycle;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  op_t op = ALU_ADD;
  logic [31:0] src1 = '0, src2 = '0, result;
  logic in_ready, out_valid, taken;
  typedef struct {
    string nm;
    logic [31:0] res;
    logic tk;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  bit seen = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  alu_multicycle #(.XLEN(32), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .taken(taken)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(string nm, op_t o, logic [31:0] a, logic [31:0] b,
                      logic [31:0] er, logic et, int lat, bit push);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout: in_ready=%b expected 1", nm, in_ready);
    end else if (push) begin
      e.nm = nm;
      e.res = er;
      e.tk = et;
      e.lat = lat;
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = op_t'($urandom);
    src1 = $urandom;
    src2 = $urandom;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask
  // Monitor: every valid cycle is compared, so held results are checked for stability too
  always @(negedge clk)
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected out_valid: result=%h taken=%b, expected no output", result, taken);
      end else begin
        if (!seen) chk({q[0].nm, " latency"}, cyc - q[0].acc, q[0].lat);
        seen = 1'b1;
        chk({q[0].nm, " result"}, result, q[0].res);
        chk({q[0].nm, " taken"}, {31'b0, taken}, {31'b0, q[0].tk});
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset result", result, 0);
    chk("reset taken", {31'b0, taken}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    send("ADD", ALU_ADD, 7, 5, 12, 0, 1, 1);
    send("SUB", ALU_SUB, 5, 7, 32'hFFFFFFFE, 0, 1, 1);
    send("LUI", ALU_LUI, 0, 32'h12345000, 32'h12345000, 0, 1, 1);
    send("ADD4", ALU_ADD4, 32'h100, 9, 32'h104, 1, 1, 1);
    send("BEQ", ALU_BEQ, 3, 3, 0, 1, 1, 1);
    send("BNE", ALU_BNE, 3, 3, 0, 0, 1, 1);
    send("BLT", ALU_BLT, 32'hFFFFFFFF, 1, 0, 1, 1, 1);
    send("BLTU", ALU_BLTU, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
    send("BGE", ALU_BGE, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
    send("BGEU", ALU_BGEU, 32'hFFFFFFFF, 1, 0, 1, 1, 1);
    send("SLL", ALU_SLL, 1, 35, 8, 0, 1, 1);
    send("SRL", ALU_SRL, 32'h80000000, 4, 32'h08000000, 0, 1, 1);
    send("SRA", ALU_SRA, 32'h80000000, 4, 32'hF8000000, 0, 1, 1);
    send("AND", ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 0, 1, 1);
    send("OR", ALU_OR, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 1, 1);
    send("XOR", ALU_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 1, 1);
    send("SLT", ALU_SLT, 32'hFFFFFFFF, 1, 1, 0, 1, 1);
    send("SLTU", ALU_SLTU, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
    send("MUL", ALU_MUL, 6, 7, 42, 0, 33, 1);
    send("MUL neg", ALU_MUL, 32'hFFFFFFFD, 5, 32'hFFFFFFF1, 0, 33, 1);
    send("MULH", ALU_MULH, 32'h80000000, 2, 32'hFFFFFFFF, 0, 33, 1);
    send("MULH m1m1", ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 33, 1);
    send("MULHU", ALU_MULHU, 32'h80000000, 2, 1, 0, 33, 1);
    send("MULHSU", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 1);
    send("DIV ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 33, 1);
    send("REM ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 0, 0, 33, 1);
    send("DIVU by0", ALU_DIVU, 1234, 0, 32'hFFFFFFFF, 0, 33, 1);
    send("REMU by0", ALU_REMU, 123, 0, 123, 0, 33, 1);
    send("DIV by0", ALU_DIV, 32'hFFFFFFFB, 0, 32'hFFFFFFFF, 0, 33, 1);
    send("REM by0", ALU_REM, 32'hFFFFFFFB, 0, 32'hFFFFFFFB, 0, 33, 1);
    send("DIV neg", ALU_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 0, 33, 1);
    send("REM neg", ALU_REM, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 0, 33, 1);
    send("DIVU", ALU_DIVU, 100, 7, 14, 0, 33, 1);
    send("REMU", ALU_REMU, 100, 7, 2, 0, 33, 1);
    wait_drain();
    out_ready = 1'b0;
    send("DIV hold", ALU_DIV, 100, 7, 14, 0, 33, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold out_valid", {31'b0, out_valid}, 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send("ADD b2b", ALU_ADD, 2, 3, 5, 0, 1, 1);
    wait_drain();
    send("DIV flushed", ALU_DIV, 1000, 3, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op = ALU_ADD;
    src1 = 1;
    src2 = 1;
    @(negedge clk);
    chk("in_ready during flush", {31'b0, in_ready}, 0);
    chk("out_valid during flush", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready after flush", {31'b0, in_ready}, 1);
    chk("out_valid after flush", {31'b0, out_valid}, 0);
    repeat (40) @(negedge clk);
    chk("out_valid long after flush", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
    send("ADD4 pre", ALU_ADD4, 32'h100, 0, 32'h104, 1, 1, 1);
    wait_drain();
    send("MUL reset", ALU_MUL, 6, 7, 42, 0, 33, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 0);
    chk("async reset result", result, 0);
    chk("async reset taken", {31'b0, taken}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after mid-op reset", {31'b0, in_ready}, 1);
    repeat (40) @(negedge clk);
    chk("out_valid after mid-op reset", {31'b0, out_valid}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
